// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: fetch/decode/issue sequencer wrapped around a combinational ALU with an 8x16 register file
module alu_issue_ctrl #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  output logic [15:0]         alu_inA,
  output logic [15:0]         alu_inB,
  output logic                alu_operation,
  input  logic [15:0]         alu_result,
  input  logic                alu_mem_update_flag,
  input  logic [2:0]          dbg_sel,
  output logic [15:0]         dbg_data,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALTED} state_t;
  state_t state;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0] ir, res_q;
  logic flag_q;
  logic [15:0] rf [0:7];
  logic [2:0] rd, rs1, rs2;
  assign rd = ir[14:12];
  assign rs1 = ir[11:9];
  assign rs2 = ir[8:6];
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign busy = state inside {FETCH, DECODE, EXEC, WB};
  assign halted = state == HALTED;
  // rf[0] is never written, so it reads as zero everywhere
  assign dbg_data = rf[dbg_sel];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= PC_WIDTH'(RESET_PC);
      ir <= '0;
      res_q <= '0;
      flag_q <= 1'b0;
      alu_inA <= '0;
      alu_inB <= '0;
      alu_operation <= 1'b0;
      retired <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= FETCH;
        FETCH: if (imem_ack) begin
          ir <= imem_rdata;
          state <= DECODE;
        end
        DECODE: if (ir == 16'h003F) state <= HALTED;
        else begin
          alu_inA <= ir[15] ? 16'h0000 : rf[rs1];
          alu_inB <= ir[15] ? {8'h00, ir[7:0]} : rf[rs2];
          alu_operation <= ir[15];
          state <= EXEC;
        end
        EXEC: begin
          res_q <= alu_result;
          flag_q <= alu_mem_update_flag;
          state <= WB;
        end
        WB: begin
          if (flag_q) begin
            if (rd != 3'd0) rf[rd] <= res_q;
            retired <= retired + 16'd1;
          end
          pc <= pc + PC_WIDTH'(1);
          state <= FETCH;
        end
        HALTED: if (start) begin
          pc <= PC_WIDTH'(RESET_PC);
          retired <= '0;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed program vectors with a bench-side ALU and instruction memory
module tb_alu_issue_ctrl;
  logic clk, rst_n, start, imem_req, imem_ack, alu_operation, alu_mem_update_flag, busy, halted;
  logic [7:0] imem_addr;
  logic [15:0] imem_rdata, alu_inA, alu_inB, alu_result, dbg_data, retired;
  logic [2:0] dbg_sel;
  logic flag_en, inj;
  logic [15:0] inj_val;
  logic start2, req2, op2, busy2, halted2;
  logic [1:0] addr2;
  logic [15:0] inA2, inB2, res2, dbg2, ret2;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .alu_inA(alu_inA), .alu_inB(alu_inB),
    .alu_operation(alu_operation), .alu_result(alu_result), .alu_mem_update_flag(alu_mem_update_flag),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .busy(busy), .halted(halted), .retired(retired)
  );

  alu_issue_ctrl #(.PC_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(16'h9112), .alu_inA(inA2), .alu_inB(inB2),
    .alu_operation(op2), .alu_result(res2), .alu_mem_update_flag(1'b1),
    .dbg_sel(3'd1), .dbg_data(dbg2), .busy(busy2), .halted(halted2), .retired(ret2)
  );

  assign alu_result = inj ? inj_val : (alu_operation ? {alu_inB[7:0], 8'h00} : alu_inA + alu_inB);
  assign alu_mem_update_flag = flag_en;
  assign res2 = op2 ? {inB2[7:0], 8'h00} : inA2 + inB2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          waits;
    bit          flag;
    bit          inj;
    logic [15:0] inj_val;
    logic [2:0]  sel;
    logic [15:0] exp;
    logic [15:0] ret;
  } vec_t;

  vec_t vt [18];
  int nvec = 0, nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] pc_m;
    logic [1:0] exp_addr [5];
    bit stable, is_halt;
    int cyc, n;
    vt[0]  = '{16'h9112, 0, 1'b1, 1'b0, 16'h0000, 3'd1, 16'h1200, 16'd1};
    vt[1]  = '{16'hA134, 0, 1'b1, 1'b0, 16'h0000, 3'd2, 16'h3400, 16'd2};
    vt[2]  = '{16'h3280, 0, 1'b1, 1'b0, 16'h0000, 3'd3, 16'h4600, 16'd3};
    vt[3]  = '{16'h003F, 0, 1'b1, 1'b0, 16'h0000, 3'd3, 16'h4600, 16'd3};
    vt[4]  = '{16'h9112, 5, 1'b1, 1'b0, 16'h0000, 3'd1, 16'h1200, 16'd1};
    vt[5]  = '{16'hA134, 5, 1'b1, 1'b0, 16'h0000, 3'd2, 16'h3400, 16'd2};
    vt[6]  = '{16'h3280, 5, 1'b1, 1'b0, 16'h0000, 3'd3, 16'h4600, 16'd3};
    vt[7]  = '{16'h9100, 0, 1'b1, 1'b1, 16'hFFFF, 3'd1, 16'hFFFF, 16'd4};
    vt[8]  = '{16'hA100, 0, 1'b1, 1'b1, 16'h0002, 3'd2, 16'h0002, 16'd5};
    vt[9]  = '{16'h4280, 0, 1'b1, 1'b0, 16'h0000, 3'd4, 16'h0001, 16'd6};
    vt[10] = '{16'h0280, 0, 1'b1, 1'b0, 16'h0000, 3'd0, 16'h0000, 16'd7};
    vt[11] = '{16'hD1AB, 0, 1'b0, 1'b0, 16'h0000, 3'd5, 16'h0000, 16'd7};
    vt[12] = '{16'h6285, 0, 1'b1, 1'b0, 16'h0000, 3'd6, 16'h0001, 16'd8};
    vt[13] = '{16'hFF12, 0, 1'b1, 1'b0, 16'h0000, 3'd7, 16'h1200, 16'd9};
    vt[14] = '{16'h7EC0, 0, 1'b1, 1'b0, 16'h0000, 3'd7, 16'h5800, 16'd10};
    vt[15] = '{16'h003F, 0, 1'b1, 1'b0, 16'h0000, 3'd4, 16'h0001, 16'd10};
    vt[16] = '{16'h5280, 0, 1'b1, 1'b0, 16'h0000, 3'd5, 16'h0001, 16'd1};
    vt[17] = '{16'h003F, 0, 1'b1, 1'b0, 16'h0000, 3'd1, 16'hFFFF, 16'd1};
    exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; imem_ack = 1'b0; imem_rdata = 16'hDEAD;
    dbg_sel = 3'd0; flag_en = 1'b1; inj = 1'b0; inj_val = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retired", retired, 16'd0);
    chk("rst_inA", alu_inA, 16'd0);
    chk("rst_inB", alu_inB, 16'd0);
    chk("rst_op", alu_operation, 1'b0);
    chk("rst_addr", imem_addr, 8'd0);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    chk("idle_ack_ignored", busy, 1'b0);
    pulse_start();
    pc_m = 8'd0;
    for (int i = 0; i < 18; i++) begin
      is_halt = vt[i].instr == 16'h003F;
      chk($sformatf("v%0d_addr", i), imem_addr, pc_m);
      chk($sformatf("v%0d_req", i), imem_req, 1'b1);
      flag_en = vt[i].flag; inj = vt[i].inj; inj_val = vt[i].inj_val;
      stable = 1'b1;
      repeat (vt[i].waits) begin
        @(negedge clk);
        if (!imem_req || imem_addr !== pc_m) stable = 1'b0;
      end
      if (vt[i].waits != 0) chk($sformatf("v%0d_stable", i), stable, 1'b1);
      imem_ack = 1'b1; imem_rdata = vt[i].instr;
      start = vt[i].waits != 0;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = 16'hDEAD;
      cyc = 1;
      while (!imem_req && !halted && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      start = 1'b0;
      chk($sformatf("v%0d_cycles", i), cyc, is_halt ? 2 : 4);
      chk($sformatf("v%0d_halted", i), halted, is_halt);
      dbg_sel = vt[i].sel;
      #1;
      chk($sformatf("v%0d_r%0d", i, vt[i].sel), dbg_data, vt[i].exp);
      chk($sformatf("v%0d_retired", i), retired, vt[i].ret);
      if (is_halt) begin
        chk($sformatf("v%0d_halt_pc", i), imem_addr, pc_m);
        if (i < 17) begin
          @(negedge clk);
          pulse_start();
          pc_m = 8'd0;
        end
      end else pc_m++;
    end
    pulse_start();
    chk("midfetch_req", imem_req, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dbg_sel = 3'd1;
    #1;
    chk("midfetch_rst_req", imem_req, 1'b0);
    chk("midfetch_rst_busy", busy, 1'b0);
    chk("midfetch_rst_retired", retired, 16'd0);
    chk("midfetch_rst_r1", dbg_data, 16'd0);
    chk("midfetch_rst_inA", alu_inA, 16'd0);
    @(negedge clk);
    chk("midfetch_idle", busy, 1'b0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!req2 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("wrap_addr%0d", k), addr2, exp_addr[k]);
      @(negedge clk);
    end
    chk("wrap_r1", dbg2, 16'h1200);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
